circulant_transpose_reader: RTL and testbench



---
 rtl/circulant_transpose_reader.sv | 131 +++++++++++++
 tb/tb_circulant_transpose_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circulant_transpose_reader.sv
// Read-side sequencer for the circulant-skewed column memory: sweeps the transposed
// read port under FIFO credit and streams the transposed matrix out over valid/ready.
module circulant_transpose_reader #(
    parameter int unsigned MATRIX_DIM = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned WORD_LEN   = 32,
    parameter int unsigned ADDR_LEN   = $clog2(MATRIX_DIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_LEN-1:0] rd_row,
    output logic [ADDR_LEN-1:0] rd_col,
    input  logic [WORD_LEN-1:0] rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WORD_LEN-1:0] m_data,
    output logic                m_last
);

    localparam int unsigned CPW = WORD_LEN / COL_WIDTH;
    localparam logic [ADDR_LEN-1:0] ROW_STEP = ADDR_LEN'(CPW);
    localparam logic [ADDR_LEN-1:0] LAST_ROW = ADDR_LEN'(MATRIX_DIM - CPW);
    localparam logic [ADDR_LEN-1:0] LAST_COL = ADDR_LEN'(MATRIX_DIM - 1);

    if ((MATRIX_DIM < 2) || ((MATRIX_DIM & (MATRIX_DIM - 1)) != 0) ||
        (COL_WIDTH == 0) || ((WORD_LEN % COL_WIDTH) != 0) || (CPW == 0) ||
        ((CPW & (CPW - 1)) != 0) || (CPW > MATRIX_DIM) ||
        (ADDR_LEN != $clog2(MATRIX_DIM))) begin : g_param_check
        $error("circulant_transpose_reader: invalid parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic                inflight;
    logic                inflight_last;
    logic                spare_valid;
    logic [WORD_LEN-1:0] spare_data;
    logic                spare_last;
    logic                pop;
    logic [2:0]          load;
    logic                credit;
    logic                last_g;
    logic                last_read;

    // Words held or already committed to the 2-entry buffer after this cycle's pop.
    assign pop       = m_valid & m_ready;
    assign load      = 3'(m_valid) + 3'(spare_valid) + 3'(inflight) - 3'(pop);
    assign credit    = load < 3'd2;
    assign rd_en     = (state == ISSUE) & credit;
    assign last_g    = rd_row == LAST_ROW;
    assign last_read = last_g & (rd_col == LAST_COL);
    assign done      = (state == DRAIN) & pop & m_last;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_row        <= '0;
            rd_col        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_last        <= 1'b0;
            spare_valid   <= 1'b0;
            spare_data    <= '0;
            spare_last    <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en & last_read;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ISSUE;
                        rd_row <= '0;
                        rd_col <= '0;
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        if (last_g) begin
                            rd_row <= '0;
                            rd_col <= rd_col + ADDR_LEN'(1);
                        end else begin
                            rd_row <= rd_row + ROW_STEP;
                        end
                        if (last_read) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Output register is the FIFO head; the spare register is the second entry.
            if (pop) begin
                if (spare_valid) begin
                    m_data      <= spare_data;
                    m_last      <= spare_last;
                    spare_valid <= inflight;
                    spare_data  <= rd_data;
                    spare_last  <= inflight_last;
                end else begin
                    m_valid <= inflight;
                    if (inflight) begin
                        m_data <= rd_data;
                        m_last <= inflight_last;
                    end
                end
            end else if (inflight) begin
                if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= rd_data;
                    m_last  <= inflight_last;
                end else begin
                    spare_valid <= 1'b1;
                    spare_data  <= rd_data;
                    spare_last  <= inflight_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_circulant_transpose_reader.sv
// Scoreboard bench for circulant_transpose_reader: 4x4 instance under directed and
// random backpressure, plus an 8x8 instance for the two-group read order.
module tb_circulant_transpose_reader;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, fix_ready, rnd_ready, rand_mode;
    logic        m_ready;
    logic        busy, done, rd_en, m_valid, m_last;
    logic [1:0]  rd_row, rd_col;
    logic [31:0] rd_data, m_data;

    logic        b_start, b_ready, b_busy, b_done, b_rd_en, b_valid, b_last;
    logic [2:0]  b_rd_row, b_rd_col;
    logic [31:0] b_rd_data, b_data;

    assign m_ready = rand_mode ? rnd_ready : fix_ready;

    circulant_transpose_reader #(.MATRIX_DIM(4), .COL_WIDTH(8), .WORD_LEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    circulant_transpose_reader #(.MATRIX_DIM(8), .COL_WIDTH(8), .WORD_LEN(32)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_data(b_rd_data),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_last(b_last)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] mem_a [8][8];
    exp_t qa[$];
    exp_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] elem_fixed(input int r, input int c);
        return 8'(((r % 16) * 16) + (c % 16));
    endfunction

    // Memory models: 1-cycle read latency, chunk k = element (row+k, col).
    always @(posedge clk) begin
        if (rd_en) begin
            for (int k = 0; k < 4; k++) rd_data[8*k +: 8] <= mem_a[int'(rd_row) + k][int'(rd_col)];
        end
        if (b_rd_en) begin
            for (int k = 0; k < 4; k++) b_rd_data[8*k +: 8] <= elem_fixed(int'(b_rd_row) + k, int'(b_rd_col));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Golden model: build the transpose, then pack each transposed row CPW elements per word.
    task automatic push_exp(input bit is_b);
        int dim;
        int groups;
        logic [7:0] t [8][8];
        exp_t e;
        dim = is_b ? 8 : 4;
        groups = dim / 4;
        for (int r = 0; r < dim; r++)
            for (int c = 0; c < dim; c++)
                t[c][r] = is_b ? elem_fixed(r, c) : mem_a[r][c];
        for (int c = 0; c < dim; c++) begin
            for (int g = 0; g < groups; g++) begin
                for (int k = 0; k < 4; k++) e.d[8*k +: 8] = t[c][g*4 + k];
                e.l = (c == dim - 1) && (g == groups - 1);
                if (is_b) qb.push_back(e);
                else qa.push_back(e);
            end
        end
    endtask

    int   ra_cnt, outst, rd_seen, done_cnt, done_cyc;
    logic hold;
    logic [32:0] held;
    exp_t ea;

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            ra_cnt = 0;
            outst  = 0;
            hold   = 1'b0;
        end else begin
            if (rd_en) begin
                chk("a_rd_row", 64'(rd_row), 64'd0);
                chk("a_rd_col", 64'(rd_col), 64'(ra_cnt % 4));
                ra_cnt++;
                outst++;
                rd_seen++;
            end
            if (hold) chk("a_stable", 64'({m_last, m_data}), 64'(held));
            if (m_valid && m_ready) begin
                outst--;
                if (qa.size() == 0) begin
                    chk("a_unexpected_word", 64'(m_data), 64'hdead);
                end else begin
                    ea = qa.pop_front();
                    chk("a_data", 64'(m_data), 64'(ea.d));
                    chk("a_last", 64'(m_last), 64'(ea.l));
                    chk("a_done_on_last", 64'(done), 64'(ea.l));
                end
            end else if (done) begin
                chk("a_done_without_handshake", 64'(done), 64'd0);
            end
            if (rd_en || (m_valid && m_ready)) chk("a_occupancy_le_2", 64'(outst > 2), 64'd0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold = m_valid && !m_ready;
            held = {m_last, m_data};
        end
    end

    int   rb_cnt, b_words, b_done_cnt;
    exp_t eb;

    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
            rb_cnt = 0;
        end else begin
            if (b_rd_en) begin
                chk("b_rd_row", 64'(b_rd_row), 64'(((rb_cnt % 16) % 2) * 4));
                chk("b_rd_col", 64'(b_rd_col), 64'((rb_cnt % 16) / 2));
                rb_cnt++;
            end
            if (b_valid && b_ready) begin
                b_words++;
                if (qb.size() == 0) begin
                    chk("b_unexpected_word", 64'(b_data), 64'hdead);
                end else begin
                    eb = qb.pop_front();
                    chk("b_data", 64'(b_data), 64'(eb.d));
                    chk("b_last", 64'(b_last), 64'(eb.l));
                end
            end
            if (b_done) b_done_cnt++;
        end
    end

    initial begin
        rnd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns the index of the cycle start was held in.
    task automatic start_a(output int t0);
        push_exp(1'b0);
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done_a(input int d0, input int budget);
        int i;
        for (i = 0; i < budget && done_cnt <= d0; i++) tick(1);
        if (done_cnt <= d0) chk("a_done_timeout", 64'd0, 64'd1);
    endtask

    int t0, d0, r0;

    initial begin
        rst = 1'b1; start = 1'b0; fix_ready = 1'b0; rand_mode = 1'b0;
        b_start = 1'b0; b_ready = 1'b1;
        rd_seen = 0; done_cnt = 0; done_cyc = 0; b_words = 0; b_done_cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mem_a[r][c] = elem_fixed(r, c);
        tick(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'({rd_row, rd_col}), 64'd0);
        chk("rst_m_out", 64'({m_valid, m_last, m_data}), 64'd0);
        rst = 1'b0;
        tick(1);

        // Basic readout with m_ready held high
        fix_ready = 1'b1;
        d0 = done_cnt;
        start_a(t0);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        chk("t1_rd_en_c1", 64'(rd_en), 64'd1);
        tick(1);
        chk("t1_valid_c2", 64'(m_valid), 64'd0);
        tick(1);
        chk("t1_valid_c3", 64'(m_valid), 64'd1);
        chk("t1_first_word", 64'(m_data), 64'h30201000);
        tick(3);
        chk("t1_done_c6", 64'(done), 64'd1);
        tick(1);
        chk("t1_busy_c7", 64'(busy), 64'd0);
        chk("t1_done_cycle", 64'(done_cyc - t0), 64'd6);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_queue_empty", 64'(qa.size()), 64'd0);

        // Consumer stalled for 10 cycles after start
        fix_ready = 1'b0;
        d0 = done_cnt;
        r0 = rd_seen;
        start_a(t0);
        tick(9);
        chk("t2_reads_le_2", 64'((rd_seen - r0) <= 2), 64'd1);
        chk("t2_valid", 64'(m_valid), 64'd1);
        chk("t2_head_word", 64'(m_data), 64'h30201000);
        fix_ready = 1'b1;
        wait_done_a(d0, 50);
        tick(1);
        chk("t2_queue_empty", 64'(qa.size()), 64'd0);

        // Start pulses while busy and in the done cycle are ignored
        d0 = done_cnt;
        start_a(t0);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("t3_done_c6", 64'(done), 64'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t3_busy_after_done", 64'(busy), 64'd0);
        tick(3);
        chk("t3_still_idle", 64'(busy), 64'd0);
        chk("t3_one_done", 64'(done_cnt - d0), 64'd1);
        chk("t3_queue_empty", 64'(qa.size()), 64'd0);

        // Reset while a read is in flight, then a fresh readout
        start_a(t0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_valid", 64'(m_valid), 64'd0);
        chk("t4_rd_en", 64'(rd_en), 64'd0);
        rst = 1'b0;
        tick(4);
        chk("t4_no_stale_output", 64'(m_valid), 64'd0);
        d0 = done_cnt;
        start_a(t0);
        wait_done_a(d0, 50);
        chk("t4_queue_empty", 64'(qa.size()), 64'd0);

        // 20 back-to-back random matrices under random m_ready
        rand_mode = 1'b1;
        for (int m = 0; m < 20; m++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) mem_a[r][c] = 8'($urandom);
            d0 = done_cnt;
            start_a(t0);
            wait_done_a(d0, 200);
        end
        chk("t5_queue_empty", 64'(qa.size()), 64'd0);
        rand_mode = 1'b0;

        // 8x8 instance: two groups per column, 16 words
        push_exp(1'b1);
        b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        for (int i = 0; i < 100 && b_done_cnt == 0; i++) tick(1);
        tick(2);
        chk("t6_done_count", 64'(b_done_cnt), 64'd1);
        chk("t6_words", 64'(b_words), 64'd16);
        chk("t6_queue_empty", 64'(qb.size()), 64'd0);
        chk("t6_busy_low", 64'(b_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
